payload_fifo: RTL

Elastic buffer directly downstream of the consumer FSM. It accepts reassembled 32-bit `pay` words over the Put/Free handshake and holds up to DEPTH words. It re-presents them, in order, to the next stage over the same handshake, so a slow sink never stalls the serial link mid-word.

---
 rtl/handshake_pkg.sv | 16 +
 rtl/payload_fifo_if.sv | 20 ++
 rtl/payload_fifo_mem.sv | 34 +++
 rtl/payload_fifo.sv | 73 +++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// handshake_pkg
// Shared types for the Put/Free handshake stages.
//   pay           : 32-bit payload word, four bytes with a in the MSB byte.
//   DEFAULT_DEPTH : default number of entries for payload_fifo.
package handshake_pkg;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
  } pay;

  localparam int DEFAULT_DEPTH = 4;

endpackage

// File: rtl/payload_fifo_if.sv
// payload_fifo_if
// One Put/Free handshake channel carrying a pay word.
//   put     : sender has a valid word on payload
//   payload : word offered by the sender
//   free    : receiver can accept a word this cycle
// A transfer happens at a posedge where put && free are both 1.
// Modports:
//   master : the sending side (drives put/payload, samples free)
//   slave  : the receiving side (samples put/payload, drives free)
interface payload_fifo_if;
  import handshake_pkg::*;

  logic put;
  pay   payload;
  logic free;

  modport master (output put, output payload, input free);
  modport slave  (input put, input payload, output free);

endinterface

// File: rtl/payload_fifo_mem.sv
// payload_fifo_mem
// DEPTH x pay storage for payload_fifo.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : mem[raddr]
// Storage has no reset; the owning FIFO tracks validity by pointers.
module payload_fifo_mem
  import handshake_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pay            wdata,
  input  logic [AW-1:0] raddr,
  output pay            rdata
);

  pay mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/payload_fifo.sv
// payload_fifo
// Elastic buffer holding up to DEPTH pay words between two Put/Free
// handshake channels, re-presenting them in arrival order.
//   clk     : single clock, all state on posedge
//   reset_L : synchronous active-low reset
//   in_if   : upstream channel (in_put, in_payload in; in_free out)
//   out_if  : downstream channel (out_put, out_payload out; out_free in)
//   count   : current occupancy, 0..DEPTH
// in_free and out_put are decoded from the count register only, so there is
// no combinational path from out_free to in_free or from in_put to out_put.
module payload_fifo
  import handshake_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_L,
  payload_fifo_if.slave         in_if,
  payload_fifo_if.master        out_if,
  output logic [CW-1:0]         count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  pay            head;

  assign in_if.free   = (count != CW'(DEPTH));
  assign out_if.put   = (count != '0);
  assign out_if.payload = head;

  assign push = in_if.put  && in_if.free;
  assign pop  = out_if.put && out_if.free;

  // Writes are gated by reset so a push presented during reset is dropped.
  payload_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push && reset_L),
    .waddr (wr_ptr),
    .wdata (in_if.payload),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers wrap by natural rollover since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
